// File: rtl/lisa_i2c_pkg.sv
// lisa_i2c_pkg: shared definitions for the lisa_i2c_seq transaction sequencer.
//   - downstream I2C master register offsets (relative to its base address)
//   - I2C CMD register encodings and STATUS bit positions
//   - sequencer register offsets, FSM state / byte-phase enums
//   - seq_cmd(): CMD byte issued for a given byte phase
package lisa_i2c_pkg;

    // Downstream I2C master register offsets
    localparam logic [6:0] I2C_OFF_RX     = 7'd3;
    localparam logic [6:0] I2C_OFF_STATUS = 7'd4;
    localparam logic [6:0] I2C_OFF_TX     = 7'd5;
    localparam logic [6:0] I2C_OFF_CMD    = 7'd6;

    // Downstream CMD encodings
    localparam logic [7:0] CMD_STA = 8'h80;
    localparam logic [7:0] CMD_STO = 8'h40;
    localparam logic [7:0] CMD_RD  = 8'h20;
    localparam logic [7:0] CMD_WR  = 8'h10;
    localparam logic [7:0] CMD_ACK = 8'h08;

    // Downstream STATUS bit positions
    localparam int I2C_ST_TIP   = 1;
    localparam int I2C_ST_AL    = 5;
    localparam int I2C_ST_RXACK = 7;

    // Sequencer register offsets
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_SADDR  = 3'd1;
    localparam logic [2:0] REG_REGPTR = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_TX,
        S_WR_CMD,
        S_GUARD,
        S_POLL,
        S_CHECK,
        S_RD_RX,
        S_FINISH
    } seq_state_e;

    // Which byte of the transaction is in flight
    typedef enum logic [1:0] {
        PH_ADDR,   // slave address + W, with START
        PH_REG,    // register pointer
        PH_RADDR,  // repeated START, slave address + R
        PH_DATA    // data bytes, direction from CTRL.dir
    } seq_phase_e;

    function automatic logic [7:0] seq_cmd(seq_phase_e ph, logic dir, logic last, logic stop);
        logic [7:0] c;
        c = CMD_WR;
        if (stop) begin
            c = CMD_STO;
        end else begin
            case (ph)
                PH_ADDR:  c = CMD_STA | CMD_WR;
                PH_REG:   c = CMD_WR;
                PH_RADDR: c = CMD_STA | CMD_WR;
                PH_DATA: begin
                    if (dir) c = last ? (CMD_RD | CMD_ACK | CMD_STO) : CMD_RD;
                    else     c = last ? (CMD_STO | CMD_WR) : CMD_WR;
                end
                default:  c = CMD_WR;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/lisa_i2c_seq.sv
// lisa_i2c_seq: autonomous I2C transaction sequencer driving the register port
// of a downstream I2C master. The CPU loads SADDR/REGPTR/DATA/len and sets GO;
// the block issues TX/CMD writes, polls STATUS.tip and collects RX bytes.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   d_addr/d_i/d_periph/d_we/d_rd   CPU register port (SEQ_BASE..SEQ_BASE+7)
//   d_o                combinational CPU read data (0 outside the window)
//   m_addr/m_di/m_we/m_rd           single-cycle accesses to the I2C master
//   m_do               combinational read data from the I2C master
//   m_own              sequencer owns the I2C port (external mux select)
//   irq                STATUS.done & CTRL.ien
//
// Optional build macro LISA_I2C_SEQ_TIMEOUT_EN: bounds each STATUS poll at
// TIMEOUT_CYCLES; on expiry STATUS.timeout is set and a STOP is issued.
module lisa_i2c_seq
    import lisa_i2c_pkg::*;
#(
    parameter logic [6:0]  I2C_BASE       = 7'h20,
    parameter logic [6:0]  SEQ_BASE       = 7'h28,   // must be 8-aligned
    parameter logic [19:0] TIMEOUT_CYCLES = 20'hFFFFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] d_addr,
    input  logic [7:0] d_i,
    input  logic       d_periph,
    input  logic       d_we,
    input  logic       d_rd,
    output logic [7:0] d_o,
    output logic [6:0] m_addr,
    output logic [7:0] m_di,
    output logic       m_we,
    output logic       m_rd,
    input  logic [7:0] m_do,
    output logic       m_own,
    output logic       irq
);

    seq_state_e r_state, w_state_nxt;
    seq_phase_e r_phase;

    logic            r_dir, r_ien;
    logic [1:0]      r_len, r_idx;
    logic [6:0]      r_saddr;
    logic [7:0]      r_regptr;
    logic [3:0][7:0] r_data;
    logic            r_busy, r_done, r_nack, r_al, r_tmo;
    logic            r_m_al, r_m_rxack;   // downstream status captured when tip drops
    logic            r_stop;              // NACK recovery STOP in flight, finish after it
    logic            r_tmo_stop;          // timeout STOP, finish without polling
    logic            r_gcnt;

    logic       w_sel, w_wr, w_go, w_last, w_rdata, w_tmo_hit;
    logic [2:0] w_off;
    logic [7:0] w_tx;
    logic [19:0] w_tcnt;

    // SEQ_BASE is 8-aligned, so the upper address bits select the window
    assign w_sel   = d_periph && (d_addr[6:3] == SEQ_BASE[6:3]);
    assign w_off   = d_addr[2:0];
    assign w_wr    = w_sel && d_we;
    assign w_go    = w_wr && (w_off == REG_CTRL) && d_i[0] && !r_busy;
    assign w_last  = (r_idx == r_len);
    assign w_rdata = (r_phase == PH_DATA) && r_dir;

`ifdef LISA_I2C_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
    logic [19:0] r_tcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             r_tcnt <= '0;
        else if (r_state == S_GUARD && r_gcnt)  r_tcnt <= '0;   // entering POLL
        else if (r_state == S_POLL)             r_tcnt <= r_tcnt + 20'd1;
    end
    assign w_tcnt = r_tcnt;
`else
    localparam bit TMO_EN = 1'b0;
    assign w_tcnt = '0;
`endif

    // Fires on the TIMEOUT_CYCLES-th consecutive POLL cycle
    assign w_tmo_hit = TMO_EN && (w_tcnt == TIMEOUT_CYCLES - 20'd1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_go) w_state_nxt = S_WR_TX;
            S_WR_TX:  w_state_nxt = S_WR_CMD;
            S_WR_CMD: w_state_nxt = r_tmo_stop ? S_FINISH : S_GUARD;
            S_GUARD:  if (r_gcnt) w_state_nxt = S_POLL;
            S_POLL: begin
                if (!m_do[I2C_ST_TIP]) w_state_nxt = S_CHECK;
                else if (w_tmo_hit)    w_state_nxt = S_WR_CMD;
            end
            S_CHECK: begin
                if (r_stop || r_m_al)          w_state_nxt = S_FINISH;
                else if (r_m_rxack && !w_rdata) w_state_nxt = S_WR_CMD;
                else begin
                    case (r_phase)
                        PH_ADDR:  w_state_nxt = S_WR_TX;
                        PH_REG:   w_state_nxt = S_WR_TX;
                        PH_RADDR: w_state_nxt = S_WR_CMD;
                        default:  w_state_nxt = r_dir ? S_RD_RX : (w_last ? S_FINISH : S_WR_TX);
                    endcase
                end
            end
            S_RD_RX:  w_state_nxt = w_last ? S_FINISH : S_WR_CMD;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        case (r_phase)
            PH_ADDR:  w_tx = {r_saddr, 1'b0};
            PH_REG:   w_tx = r_regptr;
            PH_RADDR: w_tx = {r_saddr, 1'b1};
            default:  w_tx = r_data[r_idx];
        endcase
    end

    always_comb begin
        m_addr = '0;
        m_di   = '0;
        m_we   = 1'b0;
        m_rd   = 1'b0;
        case (r_state)
            S_WR_TX: begin
                m_addr = I2C_BASE + I2C_OFF_TX;
                m_di   = w_tx;
                m_we   = 1'b1;
            end
            S_WR_CMD: begin
                m_addr = I2C_BASE + I2C_OFF_CMD;
                m_di   = seq_cmd(r_phase, r_dir, w_last, r_stop || r_tmo_stop);
                m_we   = 1'b1;
            end
            S_POLL: begin
                m_addr = I2C_BASE + I2C_OFF_STATUS;
                m_rd   = 1'b1;
            end
            S_RD_RX: begin
                m_addr = I2C_BASE + I2C_OFF_RX;
                m_rd   = 1'b1;
            end
            default: ;
        endcase
    end

    assign m_own = r_busy;
    assign irq   = r_done && r_ien;

    // ---------------- registers / datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= PH_ADDR;
            r_dir      <= 1'b0;
            r_ien      <= 1'b0;
            r_len      <= '0;
            r_idx      <= '0;
            r_saddr    <= '0;
            r_regptr   <= '0;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_nack     <= 1'b0;
            r_al       <= 1'b0;
            r_tmo      <= 1'b0;
            r_m_al     <= 1'b0;
            r_m_rxack  <= 1'b0;
            r_stop     <= 1'b0;
            r_tmo_stop <= 1'b0;
            r_gcnt     <= 1'b0;
        end else begin
            // CPU writes; transaction parameters are frozen while busy
            if (w_wr) begin
                case (w_off)
                    REG_CTRL: begin
                        r_ien <= d_i[7];
                        if (!r_busy) begin
                            r_dir <= d_i[1];
                            r_len <= d_i[3:2];
                        end
                    end
                    REG_SADDR:  if (!r_busy) r_saddr  <= d_i[6:0];
                    REG_REGPTR: if (!r_busy) r_regptr <= d_i;
                    REG_STATUS: begin
                        r_done <= 1'b0;
                        r_nack <= 1'b0;
                        r_al   <= 1'b0;
                        r_tmo  <= 1'b0;
                    end
                    default:    if (!r_busy) r_data[w_off[1:0]] <= d_i;
                endcase
            end

            if (w_go) begin
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
                r_nack     <= 1'b0;
                r_al       <= 1'b0;
                r_tmo      <= 1'b0;
                r_phase    <= PH_ADDR;
                r_idx      <= '0;
                r_stop     <= 1'b0;
                r_tmo_stop <= 1'b0;
            end

            // FSM-driven updates take priority over a same-cycle STATUS clear
            case (r_state)
                S_WR_CMD: r_gcnt <= 1'b0;
                S_GUARD:  r_gcnt <= ~r_gcnt;
                S_POLL: begin
                    if (!m_do[I2C_ST_TIP]) begin
                        r_m_al    <= m_do[I2C_ST_AL];
                        r_m_rxack <= m_do[I2C_ST_RXACK];
                    end else if (w_tmo_hit) begin
                        r_tmo      <= 1'b1;
                        r_tmo_stop <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (r_stop) begin
                        // STOP after NACK has completed
                    end else if (r_m_al) begin
                        r_al <= 1'b1;
                    end else if (r_m_rxack && !w_rdata) begin
                        r_nack <= 1'b1;
                        r_stop <= 1'b1;
                    end else begin
                        case (r_phase)
                            PH_ADDR:  r_phase <= PH_REG;
                            PH_REG:   r_phase <= r_dir ? PH_RADDR : PH_DATA;
                            PH_RADDR: r_phase <= PH_DATA;
                            default:  if (!r_dir && !w_last) r_idx <= r_idx + 2'd1;
                        endcase
                    end
                end
                S_RD_RX: begin
                    r_data[r_idx] <= m_do;
                    if (!w_last) r_idx <= r_idx + 2'd1;
                end
                S_FINISH: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- CPU read mux ----------------
    always_comb begin
        d_o = '0;
        if (w_sel && d_rd) begin
            case (w_off)
                REG_CTRL:   d_o = {r_ien, 3'b000, r_len, r_dir, 1'b0};
                REG_SADDR:  d_o = {1'b0, r_saddr};
                REG_REGPTR: d_o = r_regptr;
                REG_STATUS: d_o = {3'b000, r_tmo, r_al, r_nack, r_done, r_busy};
                default:    d_o = r_data[w_off[1:0]];
            endcase
        end
    end

endmodule
